line_state_monitor: RTL

LINE_STATE_MONITOR -- requirements
Module: line_state_monitor

---
 rtl/line_state_monitor.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/line_state_monitor.sv
// USB line-state monitor: synchronizes D+/D-, glitch-filters the decoded line
// state and tracks bus reset, end-of-packet and suspend conditions.
module line_state_monitor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 3,
  parameter int unsigned LOW_SPEED      = 0,
  parameter int unsigned RESET_CYCLES   = 120,
  parameter int unsigned SUSPEND_CYCLES = 144000,
  parameter int unsigned CNT_W          = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_dp_i,
  input  logic       usb_dn_i,
  output logic [1:0] line_state,
  output logic       line_state_valid,
  output logic       SE0_detected,
  output logic       state_change,
  output logic       eop_detected,
  output logic       bus_reset,
  output logic       suspend
);

  localparam int unsigned RUN_W = $clog2(FILTER_CYCLES + 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_SE0_WAIT,
    ST_BUS_RESET,
    ST_SUSPEND
  } state_t;

  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [SYNC_STAGES-1:0] r_dn_sync;
  logic [1:0]             w_pins;
  logic [1:0]             w_dec;

  logic [1:0]       r_cand;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_next;
  logic             w_change;
  logic [1:0]       w_ls_next;

  logic [CNT_W-1:0] r_jcnt;
  logic [CNT_W-1:0] r_se0cnt;
  logic [CNT_W-1:0] w_jcnt_next;
  logic [CNT_W-1:0] w_se0cnt_next;

  state_t r_state;
  state_t w_state_next;
  logic   w_eop;

  logic [1:0] r_line_state;
  logic       r_valid;
  logic       r_se0_det;
  logic       r_change;
  logic       r_eop;
  logic       r_bus_reset;
  logic       r_suspend;

  // Pin synchronizers; reset to 1 so the idle decode is "illegal"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_sync <= '1;
      r_dn_sync <= '1;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], usb_dp_i};
      r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], usb_dn_i};
    end
  end

  assign w_pins = {r_dp_sync[SYNC_STAGES-1], r_dn_sync[SYNC_STAGES-1]};

  always_comb begin
    w_dec = LS_ILL;
    case (w_pins)
      2'b00:   w_dec = LS_SE0;
      2'b10:   w_dec = (LOW_SPEED != 0) ? LS_K : LS_J;
      2'b01:   w_dec = (LOW_SPEED != 0) ? LS_J : LS_K;
      default: w_dec = LS_ILL;
    endcase
  end

  // Run-length filter: a new value is accepted on the edge its run reaches FILTER_CYCLES
  always_comb begin
    w_run_next = RUN_W'(1);
    if (w_dec == r_cand) begin
      w_run_next = (r_run >= RUN_W'(FILTER_CYCLES)) ? r_run : r_run + RUN_W'(1);
    end
    w_change  = (w_run_next >= RUN_W'(FILTER_CYCLES)) && (w_dec != r_line_state);
    w_ls_next = w_change ? w_dec : r_line_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand <= LS_ILL;
      r_run  <= '0;
    end else begin
      r_cand <= w_dec;
      r_run  <= w_run_next;
    end
  end

  // Duration counters follow the line state being registered this cycle
  always_comb begin
    w_jcnt_next   = '0;
    w_se0cnt_next = '0;
    if (w_ls_next == LS_J) begin
      w_jcnt_next = (r_jcnt >= CNT_W'(SUSPEND_CYCLES)) ? r_jcnt : r_jcnt + CNT_W'(1);
    end
    if (w_ls_next == LS_SE0) begin
      w_se0cnt_next = (r_se0cnt >= CNT_W'(RESET_CYCLES)) ? r_se0cnt : r_se0cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_eop        = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (w_ls_next == LS_SE0) begin
          w_state_next = ST_SE0_WAIT;
        end else if (w_ls_next == LS_J && w_jcnt_next >= CNT_W'(SUSPEND_CYCLES)) begin
          w_state_next = ST_SUSPEND;
        end
      end
      ST_SE0_WAIT: begin
        if (w_ls_next == LS_SE0) begin
          if (w_se0cnt_next >= CNT_W'(RESET_CYCLES)) begin
            w_state_next = ST_BUS_RESET;
          end
        end else begin
          w_state_next = ST_ACTIVE;
          w_eop        = (w_ls_next == LS_J);
        end
      end
      ST_BUS_RESET: begin
        if (w_ls_next != LS_SE0) begin
          w_state_next = ST_ACTIVE;
        end
      end
      ST_SUSPEND: begin
        if (w_ls_next == LS_SE0) begin
          w_state_next = ST_SE0_WAIT;
        end else if (w_ls_next != LS_J) begin
          w_state_next = ST_ACTIVE;
        end
      end
      default: w_state_next = ST_ACTIVE;
    endcase
  end

  // All status outputs are registered in the same cycle as line_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ACTIVE;
      r_jcnt       <= '0;
      r_se0cnt     <= '0;
      r_line_state <= LS_ILL;
      r_valid      <= 1'b0;
      r_se0_det    <= 1'b0;
      r_change     <= 1'b0;
      r_eop        <= 1'b0;
      r_bus_reset  <= 1'b0;
      r_suspend    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_jcnt       <= w_jcnt_next;
      r_se0cnt     <= w_se0cnt_next;
      r_line_state <= w_ls_next;
      r_valid      <= (w_ls_next != LS_ILL);
      r_se0_det    <= (w_ls_next == LS_SE0);
      r_change     <= w_change;
      r_eop        <= w_eop;
      r_bus_reset  <= (w_state_next == ST_BUS_RESET);
      r_suspend    <= (w_state_next == ST_SUSPEND);
    end
  end

  assign line_state       = r_line_state;
  assign line_state_valid = r_valid;
  assign SE0_detected     = r_se0_det;
  assign state_change     = r_change;
  assign eop_detected     = r_eop;
  assign bus_reset        = r_bus_reset;
  assign suspend          = r_suspend;

endmodule
